// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RISC-V core: sequences fetch/decode/execute/memory/writeback
// and drives the datapath mux selects, write enables and ALUOp.
//
// state      | meaning
// 0 FETCH    | read instruction at PC, PC += 4 when memory is ready
// 1 DECODE   | read registers, compute branch/jump target
// 2 MEMADR   | compute load/store address
// 3 MEMREAD  | read data memory, wait for ready
// 4 MEMWB    | write loaded data to register file
// 5 MEMWRITE | write data memory, wait for ready
// 6 EXECR    | R-type ALU operation
// 7 EXECI    | I-type ALU operation
// 8 ALUWB    | write ALU result to register file
// 9 BEQ      | compare operands, take branch on zero
// 10 JAL     | PC <- target, compute link address
// 11 TRAP    | unsupported opcode, parked until reset
module multicycle_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic       reg_write,
   output logic [1:0] alu_op,
   output logic       illegal,
   output logic       retire,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;

   logic branch_c, pc_update_c, mem_write_c, ir_write_c, reg_write_c, retire_c;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
      illegal_d = illegal_q | ((state_q == S_DECODE) && (state_d == S_TRAP));
   end

   always_comb begin
      adr_src     = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      branch_c    = 1'b0;
      pc_update_c = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      retire_c    = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_b   = 2'b10;
            result_src  = 2'b10;
            ir_write_c  = mem_ready;
            pc_update_c = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: adr_src = 1'b1;
         S_MEMWB: begin
            result_src  = 2'b01;
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src     = 1'b1;
            mem_write_c = 1'b1;
            retire_c    = mem_ready;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch_c  = 1'b1;
            retire_c  = 1'b1;
         end
         S_JAL: begin
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b10;
            pc_update_c = 1'b1;
         end
         default: ;
      endcase
      // Enables are killed combinationally so a held reset cannot corrupt memory or registers.
      pc_write  = rst_n & ((branch_c & zero) | pc_update_c);
      mem_write = rst_n & mem_write_c;
      ir_write  = rst_n & ir_write_c;
      reg_write = rst_n & reg_write_c;
      retire    = rst_n & retire_c;
   end

   always_comb begin
      case (op)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   assign illegal = illegal_q;
   assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: each instruction is expanded into its expected
// cycle-by-cycle state trace (with memory waits) and every cycle's outputs are checked.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal, retire;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, alu_op;
   logic [3:0] state;

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .imm_src(imm_src), .reg_write(reg_write), .alu_op(alu_op), .illegal(illegal),
      .retire(retire), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       mr;
   } step_t;

   step_t      q[$];
   int         n_checks = 0;
   int         n_pass = 0;
   logic       exp_illegal = 1'b0;
   logic [6:0] legal_ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                 7'b0010011, 7'b1100011, 7'b1101111};

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [1:0] exp_imm(logic [6:0] o);
      case (o)
         7'b0100011: return 2'b01;
         7'b1100011: return 2'b10;
         7'b1101111: return 2'b11;
         default:    return 2'b00;
      endcase
   endfunction

   // Control word per state as listed in the state table of the controller description.
   function automatic logic [15:0] exp_ctrl(logic [3:0] st, logic mr, logic zr,
                                            logic [6:0] o, logic rn);
      logic pcw, adr, mw, irw, rw, ret;
      logic [1:0] rs, sa, sb, ao;
      {pcw, adr, mw, irw, rw, ret} = '0;
      {rs, sa, sb, ao} = '0;
      case (st)
         4'd0:  begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
         4'd1:  begin sa = 2'b01; sb = 2'b01; end
         4'd2:  begin sa = 2'b10; sb = 2'b01; end
         4'd3:  adr = 1'b1;
         4'd4:  begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
         4'd5:  begin adr = 1'b1; mw = 1'b1; ret = mr; end
         4'd6:  begin sa = 2'b10; ao = 2'b10; end
         4'd7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
         4'd8:  begin rw = 1'b1; ret = 1'b1; end
         4'd9:  begin sa = 2'b10; ao = 2'b01; pcw = zr; ret = 1'b1; end
         4'd10: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
         default: ;
      endcase
      if (!rn) {pcw, mw, irw, rw, ret} = '0;
      return {pcw, adr, mw, irw, rs, sa, sb, exp_imm(o), rw, ao, ret};
   endfunction

   task automatic check_now(input string tag, input logic [3:0] es);
      logic [20:0] obs, expv;
      obs  = {state, illegal, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
              alu_src_b, imm_src, reg_write, alu_op, retire};
      expv = {es, exp_illegal, exp_ctrl(es, mem_ready, zero, op, rst_n)};
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: state/illegal/ctrl observed=%h expected=%h", tag, obs, expv);
   endtask

   // Expected trace for one instruction: fetch waits, decode, then the class-specific path.
   task automatic build(input logic [6:0] o, input int wf, input int wm);
      q.delete();
      for (int i = 0; i < wf; i++) q.push_back('{st: 4'd0, mr: 1'b0});
      q.push_back('{st: 4'd0, mr: 1'b1});
      q.push_back('{st: 4'd1, mr: rb()});
      case (o)
         7'b0000011: begin
            q.push_back('{st: 4'd2, mr: rb()});
            for (int i = 0; i < wm; i++) q.push_back('{st: 4'd3, mr: 1'b0});
            q.push_back('{st: 4'd3, mr: 1'b1});
            q.push_back('{st: 4'd4, mr: rb()});
         end
         7'b0100011: begin
            q.push_back('{st: 4'd2, mr: rb()});
            for (int i = 0; i < wm; i++) q.push_back('{st: 4'd5, mr: 1'b0});
            q.push_back('{st: 4'd5, mr: 1'b1});
         end
         7'b0110011: begin
            q.push_back('{st: 4'd6, mr: rb()});
            q.push_back('{st: 4'd8, mr: rb()});
         end
         7'b0010011: begin
            q.push_back('{st: 4'd7, mr: rb()});
            q.push_back('{st: 4'd8, mr: rb()});
         end
         7'b1100011: q.push_back('{st: 4'd9, mr: rb()});
         7'b1101111: begin
            q.push_back('{st: 4'd10, mr: rb()});
            q.push_back('{st: 4'd8, mr: rb()});
         end
         default: for (int i = 0; i < 21; i++) q.push_back('{st: 4'd11, mr: rb()});
      endcase
   endtask

   task automatic run_q(input logic [6:0] o, input logic zr, input string tag);
      int retires;
      bit legal;
      legal = 1'b0;
      foreach (legal_ops[k]) if (legal_ops[k] == o) legal = 1'b1;
      retires = 0;
      op   = o;
      zero = zr;
      foreach (q[i]) begin
         mem_ready = q[i].mr;
         @(negedge clk);
         check_now(tag, q[i].st);
         if (retire === 1'b1) retires++;
         @(posedge clk);
         #1;
         if (q[i].st == 4'd1 && !legal) exp_illegal = 1'b1;
      end
      if (q[q.size()-1].st != 4'd11 && q[q.size()-1].st != 4'd5 || q[q.size()-1].mr) begin
         n_checks++;
         assert (retires == (legal ? 1 : 0)) n_pass++;
         else $error("FAIL %s_retire_count: observed=%0d expected=%0d", tag, retires,
                     legal ? 1 : 0);
      end
   endtask

   task automatic do_reset(input logic [3:0] cur, input string tag);
      rst_n = 1'b0;
      #1;
      check_now({tag, "_comb"}, cur);
      @(posedge clk);
      #1;
      exp_illegal = 1'b0;
      check_now({tag, "_after"}, 4'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [6:0] rop;
      rst_n = 1'b0;
      op = 7'b0000011;
      zero = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_now("reset", 4'd0);
      rst_n = 1'b1;

      build(7'b0000011, 0, 0); run_q(7'b0000011, 1'b0, "lw");
      build(7'b0100011, 0, 3); run_q(7'b0100011, 1'b0, "sw_wait3");
      build(7'b1100011, 0, 0); run_q(7'b1100011, 1'b1, "beq_taken");
      build(7'b1100011, 0, 0); run_q(7'b1100011, 1'b0, "beq_not_taken");
      build(7'b1101111, 0, 0); run_q(7'b1101111, rb(), "jal");
      build(7'b0110011, 2, 0); run_q(7'b0110011, rb(), "rtype_fwait");
      build(7'b0010011, 0, 0); run_q(7'b0010011, rb(), "itype");

      for (int n = 0; n < 60; n++) begin
         rop = legal_ops[$urandom_range(0, 5)];
         build(rop, $urandom_range(0, 3), $urandom_range(0, 3));
         run_q(rop, rb(), "random");
      end

      build(7'b0000000, 1, 0); run_q(7'b0000000, rb(), "trap_op0");
      do_reset(4'd11, "trap_reset");
      build(7'b1110011, 0, 0); run_q(7'b1110011, rb(), "trap_system");
      do_reset(4'd11, "trap_reset2");

      build(7'b0100011, 0, 2);
      void'(q.pop_back());
      void'(q.pop_back());
      run_q(7'b0100011, 1'b0, "sw_partial");
      mem_ready = 1'b0;
      do_reset(4'd5, "memwrite_reset");

      build(7'b0000011, 1, 1); run_q(7'b0000011, rb(), "lw_after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
